// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameter values for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_BURST   = 4;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority select: first valid index starting at ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational. Backpressure: none, selection only.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any_valid
);

    localparam int SW = IDW + 1;

    logic [SW-1:0] idx;

    // Walk from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + SW'(i);
            if (idx >= SW'(NUM_REQ)) begin
                idx = idx - SW'(NUM_REQ);
            end
            if (valid[idx[IDW-1:0]]) begin
                winner    = idx[IDW-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Latency: 1 cycle arbitration, then data passes combinationally to the FIFO.
// Backpressure: fifo_full drops the granted ready in the same cycle; FIFO_WR_ARBITER_BURST_EN enables BURST-beat tenures.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BURST   = DEF_BURST,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data_in,
    input  logic                     fifo_full,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    if (NUM_REQ < 2 || BURST < 1) begin : g_bad_params
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and BURST >= 1");
    end

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] pick_id;
    logic           pick_any;
    logic [IDW-1:0] grant_nxt;
    logic           grant_vld;
    logic           xfer;
    logic           last_beat;
    logic           tenure_end;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_picker (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .winner    (pick_id),
        .any_valid (pick_any)
    );

    assign grant_vld = req_valid[grant_q];
    assign grant_nxt = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    // A beat caught by reset is never written.
    assign xfer      = (state_q == ARB_LOCK) && grant_vld && !fifo_full && !rst;

`ifdef FIFO_WR_ARBITER_BURST_EN
    localparam int                CW       = $clog2(BURST + 1);
    localparam logic [CW-1:0]     LAST_CNT = CW'(BURST - 1);

    logic [CW-1:0] beat_cnt;

    assign last_beat = (beat_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (tenure_end) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
`else
    assign last_beat = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        tenure_end   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_LOCK;
                    grant_d = pick_id;
                end
            end
            ARB_LOCK: begin
                req_ready[grant_q] = !fifo_full && !rst;
                if (xfer) begin
                    fifo_wr_en   = 1'b1;
                    fifo_data_in = req_data[int'(grant_q)*WIDTH +: WIDTH];
                end
                // Dropping valid gives the grant up even while the FIFO is full.
                if (!grant_vld || (xfer && last_beat)) begin
                    state_d    = ARB_IDLE;
                    rr_ptr_d   = grant_nxt;
                    tenure_end = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios followed by randomized traffic.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int B   = 4;
    localparam int IDW = 2;
`ifdef FIFO_WR_ARBITER_BURST_EN
    localparam int TEN = B;
`else
    localparam int TEN = 1;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic [IDW-1:0] grant_id;
    logic           busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST(B), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ready;
        logic         wr;
        logic [W-1:0] data;
        logic         bsy;
        int           grant;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] wr_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           dut_wr   = 0;

    // Stimulus variables, applied to the DUT at the start of each cycle.
    logic [N-1:0] pv;
    logic [W-1:0] pd [N];
    logic         full_d;
    logic         rst_d;

    // Reference model: owning producer (-1 when none), priority pointer, beats taken.
    int holder = -1;
    int ptr    = 0;
    int beats  = 0;
    int acc_id = -1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endfunction

    task automatic run_cycle(input bit chk_en);
        exp_t e;
        int   acc;
        rst       = rst_d;
        fifo_full = full_d;
        req_valid = pv;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = pd[i];
        e.ready = '0;
        e.wr    = 1'b0;
        e.data  = '0;
        e.bsy   = (holder >= 0);
        e.grant = holder;
        acc     = -1;
        if (!rst_d && holder >= 0) begin
            if (!full_d) e.ready[holder] = 1'b1;
            if (pv[holder] && !full_d) begin
                e.wr   = 1'b1;
                e.data = pd[holder];
                acc    = holder;
                wr_q.push_back(pd[holder]);
            end
        end
        if (chk_en) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst_d) begin
            holder = -1;
            ptr    = 0;
            beats  = 0;
        end else if (holder < 0) begin
            for (int k = 0; k < N; k++) begin
                if (holder < 0 && pv[(ptr + k) % N]) holder = (ptr + k) % N;
            end
            beats = 0;
        end else if (!pv[holder]) begin
            ptr    = (holder + 1) % N;
            holder = -1;
            beats  = 0;
        end else if (acc >= 0) begin
            beats++;
            if (beats == TEN) begin
                ptr    = (holder + 1) % N;
                holder = -1;
                beats  = 0;
            end
        end
        acc_id = acc;
    endtask

    // Monitor: compares every cycle's outputs and every FIFO write against the scoreboard.
    initial begin
        exp_t e;
        logic [W-1:0] wd;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_ready", 32'(req_ready), 32'(e.ready));
                chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr));
                chk("fifo_data_in", 32'(fifo_data_in), 32'(e.data));
                chk("busy", 32'(busy), 32'(e.bsy));
                if (e.bsy) chk("grant_id", 32'(grant_id), 32'(e.grant));
            end
            if (fifo_wr_en) begin
                dut_wr++;
                chk("write_while_full", 32'(fifo_full), 32'd0);
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(fifo_wr_en), 32'd0);
                end else begin
                    wd = wr_q.pop_front();
                    chk("write_data", 32'(fifo_data_in), 32'(wd));
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        rst_d  = 1'b1;
        full_d = 1'b0;
        pv     = '0;
        for (int i = 0; i < N; i++) pd[i] = '0;

        // Reset, then idle.
        run_cycle(1'b0);
        run_cycle(1'b1);
        rst_d = 1'b0;
        for (int c = 0; c < 10; c++) run_cycle(1'b1);
        chk("grant_id_after_reset", 32'(grant_id), 32'd0);

        // All producers valid, FIFO never full.
        pv = '1;
        for (int i = 0; i < N; i++) pd[i] = W'(i * 16);
        base = dut_wr;
        for (int c = 0; c < 20; c++) begin
            run_cycle(1'b1);
            if (acc_id >= 0) pd[acc_id] = pd[acc_id] + 1'b1;
        end
        chk("all_valid_write_count", 32'(dut_wr - base), (TEN == 1) ? 32'd10 : 32'd16);
        pv = '0;
        for (int c = 0; c < 3; c++) run_cycle(1'b1);

        // Producer 2 alone sends 0x10..0x17.
        pv    = 4'b0100;
        pd[2] = 8'h10;
        n     = 0;
        base  = dut_wr;
        for (int c = 0; c < 60 && n < 8; c++) begin
            run_cycle(1'b1);
            if (acc_id == 2) begin
                n++;
                pd[2] = pd[2] + 1'b1;
                if (n == 8) pv[2] = 1'b0;
            end
        end
        for (int c = 0; c < 3; c++) run_cycle(1'b1);
        chk("p2_write_count", 32'(dut_wr - base), 32'd8);

        // Producer 1 stalled by a full FIFO for 5 cycles.
        pv     = 4'b0010;
        pd[1]  = 8'hA5;
        full_d = 1'b1;
        base   = dut_wr;
        for (int c = 0; c < 6; c++) run_cycle(1'b1);
        chk("no_write_while_full", 32'(dut_wr - base), 32'd0);
        full_d = 1'b0;
        run_cycle(1'b1);
        chk("write_after_full_drops", 32'(dut_wr - base), 32'd1);
        pv = '0;
        for (int c = 0; c < 3; c++) run_cycle(1'b1);

        // Producer 3 drops valid after two beats; producer 0 takes over.
        pv    = 4'b1000;
        pd[3] = 8'h30;
        n     = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            run_cycle(1'b1);
            if (acc_id == 3) begin
                n++;
                pd[3] = pd[3] + 1'b1;
            end
        end
        pv    = 4'b0001;
        pd[0] = 8'h40;
        n     = 0;
        for (int c = 0; c < 10 && n < 1; c++) begin
            run_cycle(1'b1);
            if (acc_id == 0) n++;
        end
        pv = '0;
        for (int c = 0; c < 3; c++) run_cycle(1'b1);

        // Reset while locked and stalled.
        pv     = 4'b0010;
        pd[1]  = 8'h5A;
        full_d = 1'b1;
        for (int c = 0; c < 3; c++) run_cycle(1'b1);
        rst_d = 1'b1;
        run_cycle(1'b1);
        rst_d  = 1'b0;
        full_d = 1'b0;
        pv     = '1;
        for (int i = 0; i < N; i++) pd[i] = W'(8'h60 + i);
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b1);
            if (acc_id >= 0) pd[acc_id] = pd[acc_id] + 1'b1;
        end

        // Randomized traffic with stalls, drops and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_d  = ($urandom_range(0, 299) == 0);
            full_d = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (acc_id == i) begin
                    pv[i] = 1'($urandom_range(0, 1));
                    pd[i] = W'($urandom);
                end else if (!pv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pv[i] = 1'b1;
                        pd[i] = W'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            run_cycle(1'b1);
        end

        rst_d  = 1'b0;
        full_d = 1'b0;
        pv     = '0;
        for (int c = 0; c < 5; c++) run_cycle(1'b1);
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
